// File: rtl/raw_src_pkg.sv
// ----------------------------------------------------------------------------
// raw_src_pkg
// Shared definitions for the synthetic raw Bayer camera source:
//   - state_t      : frame timing FSM states
//   - MODE_*       : pattern select codes for the Mode input
//   - BAR_RGB      : colour-bar table, one {R,G,B} bit triple per bar
//   - SITE_*       : Bayer site codes indexed by {line[0], pixel[0]}
// ----------------------------------------------------------------------------
package raw_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VSYNC      = 3'd1,
        ST_VBLANK_TOP = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_VBLANK_BOT = 3'd4
    } state_t;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam logic [9:0] PIX_FULL = 10'h3FF;

    // Bar colours left to right; bit 2 = R, bit 1 = G, bit 0 = B.
    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    // Bayer sites: even lines are G,R,G,R...; odd lines are B,G,B,G...
    localparam logic [1:0] SITE_G_R = 2'b00; // green on a red line
    localparam logic [1:0] SITE_R   = 2'b01;
    localparam logic [1:0] SITE_B   = 2'b10;
    localparam logic [1:0] SITE_G_B = 2'b11; // green on a blue line

endpackage

// File: rtl/raw_pattern_gen.sv
// ----------------------------------------------------------------------------
// raw_pattern_gen
// Purely combinational test-pattern value for one Bayer pixel.
// Ports:
//   px        in  10  active pixel index (low bits)
//   ln_odd    in   1  active line index bit 0 (selects R/G or G/B line)
//   ln_bit3   in   1  active line index bit 3 (checkerboard row phase)
//   bar       in   3  colour-bar index for the current pixel
//   mode      in   2  latched pattern select
//   const_val in  10  latched constant value for MODE_CONST
//   noise     in   2  LFSR bits (only when RAW_NOISE_EN is defined)
//   pix       out 10  pattern value
// Build option: RAW_NOISE_EN adds the noise port and XORs it into pix[1:0]
// for every mode except MODE_CONST.
// ----------------------------------------------------------------------------
module raw_pattern_gen (
    input  logic [9:0] px,
    input  logic       ln_odd,
    input  logic       ln_bit3,
    input  logic [2:0] bar,
    input  logic [1:0] mode,
    input  logic [9:0] const_val,
`ifdef RAW_NOISE_EN
    input  logic [1:0] noise,
`endif
    output logic [9:0] pix
);
    import raw_src_pkg::*;

    logic [2:0] rgb;
    logic       chan_on;
    logic [9:0] pat;

    always_comb begin
        rgb = BAR_RGB[bar];

        // Pick the colour channel sampled at this Bayer site.
        case ({ln_odd, px[0]})
            SITE_R:  chan_on = rgb[2];
            SITE_B:  chan_on = rgb[0];
            default: chan_on = rgb[1];
        endcase

        case (mode)
            MODE_BARS:  pat = chan_on ? PIX_FULL : 10'd0;
            MODE_RAMP:  pat = px;
            MODE_CHECK: pat = (px[3] ^ ln_bit3) ? PIX_FULL : 10'd0;
            default:    pat = const_val;
        endcase

        pix = pat;
`ifdef RAW_NOISE_EN
        if (mode != MODE_CONST) begin
            pix = {pat[9:2], pat[1:0] ^ noise};
        end
`endif
    end

endmodule

// File: rtl/raw_bayer_source.sv
// ----------------------------------------------------------------------------
// raw_bayer_source
// Synthetic 10-bit raw Bayer camera transmitter producing the Data/HS/VS
// interface of a D8M sensor: VS lines, free-run blank lines, active lines
// carrying a Bayer-mosaiced test pattern, then bottom blanking.
// Ports:
//   Clk        in   1  pixel clock
//   RST        in   1  synchronous active-high reset
//   En         in   1  frame enable, only looked at on frame boundaries
//   Mode       in   2  pattern select (bars, ramp, checkerboard, constant)
//   ConstVal   in  10  constant pixel value for the constant pattern
//   Data       out 10  raw Bayer pixel, aligned with HS
//   HS         out  1  line valid
//   VS         out  1  frame sync
//   Busy       out  1  frame in progress
//   FrameDone  out  1  pulse on the last clock of a frame
// Build option: define RAW_NOISE_EN to add a 16-bit LFSR whose two low bits
// dither Data[1:0] in every mode except the constant pattern.
// ----------------------------------------------------------------------------
module raw_bayer_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 793,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 2,
    parameter int FREE_RUN = 44,
    parameter int V_BACK   = 2
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       En,
    input  logic [1:0] Mode,
    input  logic [9:0] ConstVal,
    output logic [9:0] Data,
    output logic       HS,
    output logic       VS,
    output logic       Busy,
    output logic       FrameDone
);
    import raw_src_pkg::*;

    localparam int V_TOTAL = VS_LINES + FREE_RUN + V_ACTIVE + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST  = VW'(VS_LINES - 1);
    localparam logic [VW-1:0] TOP_LAST = VW'(VS_LINES + FREE_RUN - 1);
    localparam logic [VW-1:0] ACT_LAST = VW'(VS_LINES + FREE_RUN + V_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_LEN - 1);

    state_t          state_q,   state_d;
    logic [HW-1:0]   hcnt_q,    hcnt_d;
    logic [VW-1:0]   vcnt_q,    vcnt_d;     // line within the whole frame
    logic [3:0]      ln_q,      ln_d;       // only bits 0 and 3 matter
    logic [2:0]      bar_q,     bar_d;
    logic [BW-1:0]   bar_cnt_q, bar_cnt_d;
    logic [1:0]      mode_q,    mode_d;
    logic [9:0]      const_q,   const_d;

    logic [9:0]      data_q, data_d;
    logic            hs_q,   hs_d;
    logic            vs_q,   vs_d;
    logic            busy_q, busy_d;
    logic            fd_q,   fd_d;

    logic            line_end;
    logic [9:0]      px;
    logic [9:0]      pix;

    // Timing FSM and counters. Everything is computed for the *next* cycle
    // so the registered outputs line up with the registered counters.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        ln_d      = ln_q;
        mode_d    = mode_q;
        const_d   = const_q;
        line_end  = (hcnt_q == H_LAST);

        if (state_q == ST_IDLE) begin
            hcnt_d = '0;
            vcnt_d = '0;
            ln_d   = '0;
            if (En) begin
                state_d = ST_VSYNC;
                mode_d  = Mode;
                const_d = ConstVal;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
                case (state_q)
                    ST_VSYNC: begin
                        if (vcnt_q == VS_LAST) state_d = ST_VBLANK_TOP;
                    end
                    ST_VBLANK_TOP: begin
                        if (vcnt_q == TOP_LAST) begin
                            state_d = ST_ACTIVE;
                            ln_d    = '0;
                        end
                    end
                    ST_ACTIVE: begin
                        ln_d = ln_q + 1'b1;
                        if (vcnt_q == ACT_LAST) state_d = ST_VBLANK_BOT;
                    end
                    ST_VBLANK_BOT: begin
                        // Back-to-back frames: no idle gap when En stays high.
                        if (vcnt_q == V_LAST) begin
                            if (En) begin
                                state_d = ST_VSYNC;
                                mode_d  = Mode;
                                const_d = ConstVal;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Bar index tracks hcnt_d / BAR_LEN with a small sub-counter instead of
    // a divider; it restarts at every line start.
    always_comb begin
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        if (hcnt_d == '0) begin
            bar_d     = '0;
            bar_cnt_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_d     = bar_q + 1'b1;
            bar_cnt_d = '0;
        end else begin
            bar_cnt_d = bar_cnt_q + 1'b1;
        end
    end

    assign px     = 10'(hcnt_d);
    assign hs_d   = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT_C);
    assign vs_d   = (state_d == ST_VSYNC);
    assign busy_d = (state_d != ST_IDLE);
    assign fd_d   = (state_d == ST_VBLANK_BOT) && (vcnt_d == V_LAST) && (hcnt_d == H_LAST);
    assign data_d = hs_d ? pix : 10'd0;

`ifdef RAW_NOISE_EN
    // Fibonacci LFSR, taps 16,14,13,11; steps once per active pixel and the
    // current value dithers that pixel.
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = hs_d ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]}
                         : lfsr_q;
`endif

    raw_pattern_gen u_pattern (
        .px        (px),
        .ln_odd    (ln_d[0]),
        .ln_bit3   (ln_d[3]),
        .bar       (bar_d),
        .mode      (mode_d),
        .const_val (const_d),
`ifdef RAW_NOISE_EN
        .noise     (lfsr_q[1:0]),
`endif
        .pix       (pix)
    );

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            ln_q      <= '0;
            bar_q     <= '0;
            bar_cnt_q <= '0;
            mode_q    <= '0;
            const_q   <= '0;
            data_q    <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
`ifdef RAW_NOISE_EN
            lfsr_q    <= 16'hACE1;
`endif
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            ln_q      <= ln_d;
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
            mode_q    <= mode_d;
            const_q   <= const_d;
            data_q    <= data_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            busy_q    <= busy_d;
            fd_q      <= fd_d;
`ifdef RAW_NOISE_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign Data      = data_q;
    assign HS        = hs_q;
    assign VS        = vs_q;
    assign Busy      = busy_q;
    assign FrameDone = fd_q;

endmodule

// File: tb/tb_raw_bayer_source.sv
// ----------------------------------------------------------------------------
// tb_raw_bayer_source
// Directed bench for raw_bayer_source with a reduced frame:
// 16 active / 24 total clocks per line, 1 VS line, 2 free-run lines,
// 4 active lines, 1 bottom line => 8 lines = 192 clocks per frame.
// Cycle 1 of a frame is the first clock with VS high.
// ----------------------------------------------------------------------------
module tb_raw_bayer_source;

    localparam int HA = 16, HT = 24, VA = 4, VSL = 1, FR = 2, VB = 1;
    localparam int FRAME = (VSL + FR + VA + VB) * HT;
    localparam int ACT0  = VSL + FR;   // first active line of the frame
`ifdef RAW_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       RST = 1'b1;
    logic       En = 1'b0;
    logic [1:0] Mode = 2'd0;
    logic [9:0] ConstVal = 10'd0;
    logic [9:0] Data;
    logic       HS, VS, Busy, FrameDone;

    int tests = 0;
    int fails = 0;
    logic [9:0] cap [VA][HA];

    always #5 Clk = ~Clk;

    raw_bayer_source #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA),
        .VS_LINES(VSL), .FREE_RUN(FR), .V_BACK(VB)
    ) dut (
        .Clk(Clk), .RST(RST), .En(En), .Mode(Mode), .ConstVal(ConstVal),
        .Data(Data), .HS(HS), .VS(VS), .Busy(Busy), .FrameDone(FrameDone)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Independent pattern model: bar = px / (HA/8), colour table from the
    // bar order, Bayer site from line/pixel parity.
    function automatic logic [9:0] model_pix(input int mode, input logic [9:0] cv,
                                             input int px, input int ln);
        logic [2:0] rgb;
        logic       on;
        case (px / (HA / 8))
            0: rgb = 3'b111; 1: rgb = 3'b110; 2: rgb = 3'b011; 3: rgb = 3'b010;
            4: rgb = 3'b101; 5: rgb = 3'b100; 6: rgb = 3'b001; default: rgb = 3'b000;
        endcase
        if (ln % 2 == 0) on = (px % 2 == 0) ? rgb[1] : rgb[2];
        else             on = (px % 2 == 0) ? rgb[0] : rgb[1];
        case (mode)
            0:       return on ? 10'h3FF : 10'h000;
            1:       return 10'(px);
            2:       return ((((px / 8) % 2) ^ ((ln / 8) % 2)) != 0) ? 10'h3FF : 10'h000;
            default: return cv;
        endcase
    endfunction

    // With noise built in, only Data[9:2] is deterministic for modes 0-2.
    function automatic logic [9:0] mask(input logic [9:0] d, input int mode);
        return (NOISE && mode != 3) ? (d & 10'h3FC) : d;
    endfunction

    // Runs one full frame from cycle 1 to cycle FRAME, checking control
    // outputs and Data every cycle. At cycle chg_at the inputs are changed
    // after that cycle's sample.
    task automatic run_frame(input string name, input int exp_mode, input logic [9:0] exp_cv,
                             input int chg_at, input logic [1:0] chg_mode,
                             input logic [9:0] chg_cv, input logic chg_en);
        for (int c = 1; c <= FRAME; c++) begin
            int pos, line, h;
            logic exp_hs;
            logic [3:0] exp_ctl, got_ctl;
            logic [9:0] exp_d;
            tick();
            pos    = c - 1;
            line   = pos / HT;
            h      = pos % HT;
            exp_hs = (line >= ACT0) && (line < ACT0 + VA) && (h < HA);
            exp_ctl = {1'b1, line < VSL, exp_hs, c == FRAME};
            got_ctl = {Busy, VS, HS, FrameDone};
            exp_d  = exp_hs ? model_pix(exp_mode, exp_cv, h, line - ACT0) : 10'd0;
            tests++;
            if (got_ctl !== exp_ctl) begin
                fails++;
                $display("FAIL %s ctl cycle %0d: got {busy,vs,hs,fd}=%b expected %b",
                         name, c, got_ctl, exp_ctl);
            end
            tests++;
            if (mask(Data, exp_mode) !== mask(exp_d, exp_mode)) begin
                fails++;
                $display("FAIL %s data cycle %0d: got %h expected %h", name, c, Data, exp_d);
            end
            if (exp_hs) cap[line - ACT0][h] = Data;
            if (c == chg_at) begin
                Mode = chg_mode;
                ConstVal = chg_cv;
                En = chg_en;
            end
        end
        $display("[TB] frame %s done", name);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        En = 1'b0;
        tick();
        tick();
        tests++;
        if ({Data, HS, VS, Busy, FrameDone} !== 14'd0) begin
            fails++;
            $display("FAIL reset: got data=%h hs=%b vs=%b busy=%b fd=%b expected all 0",
                     Data, HS, VS, Busy, FrameDone);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_timing();
        RST = 1'b0;
        En = 1'b1;
        Mode = 2'd1;
        run_frame("timing", 1, 10'd0, 0, 2'd1, 10'd0, 1'b1);
    endtask

    task automatic test_ramp();
        // Back-to-back: cycle 1 of this frame is cycle 193 overall.
        run_frame("ramp", 1, 10'd0, 0, 2'd1, 10'd0, 1'b1);
    endtask

    task automatic test_colour_bars();
        int tl [7] = '{0, 0, 0, 0, 1, 1, 0};
        int tp [7] = '{0, 1, 14, 15, 10, 11, 11};
        logic [9:0] tv [7] = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF};
        Mode = 2'd0;
        run_frame("bars", 0, 10'd0, 0, 2'd0, 10'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (mask(cap[tl[i]][tp[i]], 0) !== mask(tv[i], 0)) begin
                fails++;
                $display("FAIL bars line %0d px %0d: got %h expected %h",
                         tl[i], tp[i], cap[tl[i]][tp[i]], tv[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        Mode = 2'd1;
        run_frame("mode_hold", 1, 10'd0, 100, 2'd3, 10'h155, 1'b1);
        run_frame("mode_const", 3, 10'h155, 0, 2'd3, 10'h155, 1'b1);
    endtask

    task automatic test_en_drop();
        run_frame("en_drop", 3, 10'h155, 50, 2'd3, 10'h155, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if ({Data, HS, VS, Busy, FrameDone} !== 14'd0) begin
                fails++;
                $display("FAIL idle_after_drop cycle %0d: got data=%h hs=%b vs=%b busy=%b fd=%b expected all 0",
                         c, Data, HS, VS, Busy, FrameDone);
            end
        end
    endtask

    task automatic test_reset_mid();
        Mode = 2'd1;
        En = 1'b1;
        // Cycle 125 = line 5 of the frame = active line 2, pixel 4.
        for (int c = 1; c <= 125; c++) tick();
        tests++;
        if ({HS, Data} !== {1'b1, 10'd4}) begin
            fails++;
            $display("FAIL mid_frame_pre: got hs=%b data=%h expected hs=1 data=004", HS, Data);
        end
        RST = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if ({Data, HS, VS, Busy, FrameDone} !== 14'd0) begin
                fails++;
                $display("FAIL reset_mid cycle %0d: got data=%h hs=%b vs=%b busy=%b fd=%b expected all 0",
                         c, Data, HS, VS, Busy, FrameDone);
            end
        end
        RST = 1'b0;
        run_frame("after_reset", 1, 10'd0, 0, 2'd1, 10'd0, 1'b1);
    endtask

    task automatic test_noise();
        logic [15:0] l;
        logic [9:0]  p;
        logic [1:0]  exp_lo;
        RST = 1'b1;
        En = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        En = 1'b1;
        Mode = 2'd2;
        run_frame("noise", 2, 10'd0, 0, 2'd2, 10'd0, 1'b0);
        l = 16'hACE1;
        for (int ln = 0; ln < VA; ln++) begin
            for (int px = 0; px < HA; px++) begin
                p = model_pix(2, 10'd0, px, ln);
                exp_lo = p[1:0] ^ l[1:0];
                tests++;
                if (cap[ln][px][1:0] !== exp_lo) begin
                    fails++;
                    $display("FAIL noise line %0d px %0d: got low bits %b expected %b",
                             ln, px, cap[ln][px][1:0], exp_lo);
                end
                l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_ramp();
        test_colour_bars();
        test_mode_change();
        test_en_drop();
        test_reset_mid();
        if (NOISE) test_noise();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
